// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction-cache controller.
//
// Address layout (10-bit byte PC):
//   [9:7] tag   [6:4] index   [3:2] word offset   [1:0] ignored
package icache_pkg;

  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned TAG_W       = 3;
  localparam int unsigned INDEX_W     = 3;
  localparam int unsigned OFFSET_W    = 2;
  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned STAT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
//
// Ports:
//   clock, reset      - clock; synchronous active-high reset clears all valid bits
//   rd_index          - line selected for the combinational read
//   rd_valid/rd_tag/rd_data - contents of the selected line
//   wr_en             - write the line at wr_index this cycle
//   wr_index/wr_tag/wr_data - line, tag and block to store (valid is set on write)
module icache_line_array #(
  parameter int unsigned NUM_LINES   = 8,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned INDEX_W     = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [INDEX_W-1:0]         rd_index,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [BLOCK_BYTES*8-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [INDEX_W-1:0]         wr_index,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [BLOCK_BYTES*8-1:0]   wr_data
);

  logic [NUM_LINES-1:0]     valid_q;
  logic [TAG_W-1:0]         tag_q  [NUM_LINES];
  logic [BLOCK_BYTES*8-1:0] data_q [NUM_LINES];

  // Only the valid bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
//
// Hits return the instruction in the same cycle; a miss stalls the CPU
// (busywait) while one 16-byte block is fetched: IDLE -> MEM_READ -> UPDATE.
//
// Ports:
//   clock, reset     - clock; synchronous active-high reset
//   read, address    - CPU fetch request and byte PC
//   readinst         - fetched instruction (zero when not hitting)
//   busywait         - CPU stall
//   mem_read, mem_address, mem_readdata, mem_busywait - block-read interface
//   hit_count, miss_count - saturating statistics, present only when
//                           ICACHE_STATS_EN is defined
module icache_ctrl #(
  parameter int unsigned NUM_LINES   = 8,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic [9:0]               address,
  output logic [31:0]              readinst,
  output logic                     busywait,
  output logic                     mem_read,
  output logic [5:0]               mem_address,
  input  logic [BLOCK_BYTES*8-1:0] mem_readdata,
  input  logic                     mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
`endif
);

  import icache_pkg::*;

  state_t state_q, state_d;

  logic [TAG_W-1:0]         req_tag;
  logic [INDEX_W-1:0]       req_index;
  logic [OFFSET_W-1:0]      req_offset;
  logic                     unused_byte_sel;

  logic [TAG_W-1:0]         fill_tag_q;
  logic [INDEX_W-1:0]       fill_index_q;
  logic [BLOCK_BYTES*8-1:0] fill_data_q;

  logic                     line_valid;
  logic [TAG_W-1:0]         line_tag;
  logic [BLOCK_BYTES*8-1:0] line_data;
  logic                     line_wr_en;

  logic                     hit;
  logic                     miss_start;

  assign req_tag         = address[9:7];
  assign req_index       = address[6:4];
  assign req_offset      = address[3:2];
  assign unused_byte_sel = ^address[1:0];

  icache_line_array #(
    .NUM_LINES   (NUM_LINES),
    .BLOCK_BYTES (BLOCK_BYTES),
    .TAG_W       (TAG_W),
    .INDEX_W     (INDEX_W)
  ) u_lines (
    .clock    (clock),
    .reset    (reset),
    .rd_index (req_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (line_wr_en),
    .wr_index (fill_index_q),
    .wr_tag   (fill_tag_q),
    .wr_data  (fill_data_q)
  );

  assign hit = (state_q == IDLE) && read && line_valid && (line_tag == req_tag);

  always_comb begin
    readinst = '0;
    if (hit) begin
      readinst = line_data[{req_offset, 5'b0} +: WORD_W];
    end
  end

  assign busywait = !reset && ((state_q != IDLE) || (read && !hit));
  assign mem_read = (state_q == MEM_READ);
  assign mem_address = {fill_tag_q, fill_index_q};

  // Reset in UPDATE must not commit the block, so the write is gated here.
  assign line_wr_en = (state_q == UPDATE) && !reset;

  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read && !hit) begin
          state_d    = MEM_READ;
          miss_start = 1'b1;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        fill_tag_q   <= req_tag;
        fill_index_q <= req_index;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == MEM_READ && !mem_busywait) begin
      fill_data_q <= mem_readdata;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss_start && miss_count != '1) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl.
module tb_icache_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  readinst;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] BLK0 = {32'h0007_0047, 32'h0006_0031, 32'h0005_0023, 32'h0004_0019};
  localparam logic [127:0] BLK8 = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

  always #5 clock = ~clock;

  icache_ctrl #(
    .NUM_LINES   (8),
    .BLOCK_BYTES (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .readinst     (readinst),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    read         = 1'b0;
    address      = 10'h000;
    mem_readdata = '0;
    mem_busywait = 1'b1;
    step();
    step();

    // Reset state, including busywait held low during reset despite a miss.
    read = 1'b1;
    #1;
    check("rst_busywait", {31'b0, busywait}, 32'd0);
    read  = 1'b0;
    reset = 1'b0;
    step();
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_addr", {26'b0, mem_address}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hits", {16'b0, hit_count}, 32'd0);
    check("rst_misses", {16'b0, miss_count}, 32'd0);
`endif

    // Cold miss on 0x000.
    read    = 1'b1;
    address = 10'h000;
    #1;
    check("cold_busywait", {31'b0, busywait}, 32'd1);
    check("cold_readinst", readinst, 32'h0);
    check("cold_idle_memrd", {31'b0, mem_read}, 32'd0);
    step();
    check("cold_mem_read", {31'b0, mem_read}, 32'd1);
    check("cold_mem_addr", {26'b0, mem_address}, 32'd0);
    step();
    check("cold_hold_mem_read", {31'b0, mem_read}, 32'd1);
    mem_busywait = 1'b0;
    mem_readdata = BLK0;
    step();
    check("cold_update_memrd", {31'b0, mem_read}, 32'd0);
    check("cold_update_busy", {31'b0, busywait}, 32'd1);
    mem_busywait = 1'b1;
    mem_readdata = '0;
    step();
    check("cold_done_busy", {31'b0, busywait}, 32'd0);
    check("cold_done_inst", readinst, 32'h0004_0019);

    // Hits, zero latency, byte bits ignored.
    address = 10'h004;
    #1;
    check("hit_w1_inst", readinst, 32'h0005_0023);
    check("hit_w1_busy", {31'b0, busywait}, 32'd0);
    address = 10'h00F;
    #1;
    check("hit_w3_inst", readinst, 32'h0007_0047);
    address = 10'h007;
    step();
    check("hit_w1_lowbits", readinst, 32'h0005_0023);
    check("hit_no_memrd", {31'b0, mem_read}, 32'd0);

    // Conflict miss on 0x080 replaces line 0; address changes mid-fill are ignored.
    address = 10'h080;
    #1;
    check("conf_busy", {31'b0, busywait}, 32'd1);
    check("conf_inst", readinst, 32'h0);
    step();
    check("conf_mem_read", {31'b0, mem_read}, 32'd1);
    check("conf_mem_addr", {26'b0, mem_address}, 32'd8);
    address = 10'h000;
    #1;
    check("conf_midfill_busy", {31'b0, busywait}, 32'd1);
    check("conf_midfill_inst", readinst, 32'h0);
    mem_busywait = 1'b0;
    mem_readdata = BLK8;
    step();
    check("conf_midfill_addr", {26'b0, mem_address}, 32'd8);
    mem_busywait = 1'b1;
    step();
    address = 10'h088;
    #1;
    check("conf_new_hit", readinst, 32'hB000_0002);
    check("conf_new_busy", {31'b0, busywait}, 32'd0);
    address = 10'h000;
    #1;
    check("conf_old_miss", {31'b0, busywait}, 32'd1);
    step();
    check("conf_old_memaddr", {26'b0, mem_address}, 32'd0);
    check("conf_old_memrd", {31'b0, mem_read}, 32'd1);

    // Reset mid-fill (in MEM_READ for 0x000).
    reset = 1'b1;
    #1;
    check("rmid_busy_in_rst", {31'b0, busywait}, 32'd0);
    step();
    reset = 1'b0;
    check("rmid_mem_read", {31'b0, mem_read}, 32'd0);
    check("rmid_mem_addr", {26'b0, mem_address}, 32'd0);
    address = 10'h080;
    #1;
    check("rmid_080_miss", {31'b0, busywait}, 32'd1);
    address = 10'h000;
    #1;
    check("rmid_000_miss", {31'b0, busywait}, 32'd1);
    check("rmid_000_inst", readinst, 32'h0);
    read = 1'b0;
    #1;

    // Idle sweep: no stall and no memory traffic while read is low.
    for (int a = 0; a < 256; a++) begin
      address = 10'(a << 2);
      #1;
      check("idle_busy", {31'b0, busywait}, 32'd0);
      step();
      check("idle_memrd", {31'b0, mem_read}, 32'd0);
    end

`ifdef ICACHE_STATS_EN
    // One miss then three hit cycles from a fresh reset.
    reset = 1'b1;
    step();
    reset        = 1'b0;
    read         = 1'b1;
    address      = 10'h000;
    mem_busywait = 1'b0;
    mem_readdata = BLK0;
    step();
    step();
    step();
    check("stat_fill_done", {31'b0, busywait}, 32'd0);
    step();
    step();
    step();
    read = 1'b0;
    #1;
    check("stat_misses", {16'b0, miss_count}, 32'd1);
    check("stat_hits", {16'b0, hit_count}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first; clock and reset are the only clock/reset:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- read  in  1  CPU instruction-fetch request
- address  in  10  CPU byte PC; [1:0] ignored, [3:2] word offset, [6:4] index, [9:7] tag
- readinst  out  32  fetched instruction
- busywait  out  1  CPU stall request
- mem_read  out  1  block-read request to instruction memory
- mem_address  out  6  block address {tag,index}
- mem_readdata  in  128  16-byte block; byte n at bits [8n+7:8n]
- mem_busywait  in  1  memory busy
REQ-002 SHALL have parameters (name, default, meaning): NUM_LINES, 8, direct-mapped lines; BLOCK_BYTES, 16, bytes per line.

Function
REQ-003 SHALL keep per line: valid bit, 3-bit tag, 128-bit data.
REQ-004 SHALL, in IDLE, compute hit = read & valid[index] & (tag[index]==address[9:7]) combinationally.
REQ-005 SHALL, on hit, drive readinst = data word address[3:2] (word k = bits [32k+31:32k]) and busywait=0 in the same cycle; zero latency.
REQ-006 SHALL drive readinst=32'h0 whenever there is no hit.
REQ-007 SHALL drive busywait=1 combinationally on a miss in IDLE (read high, no hit) and in every non-IDLE state.
REQ-008 SHALL drive busywait=0 and mem_read=0 when read=0 in IDLE, regardless of address.
REQ-009 SHALL implement FSM IDLE -> MEM_READ -> UPDATE -> IDLE.
REQ-010 SHALL, at the posedge where a miss is seen in IDLE, latch {tag,index} into mem_address and enter MEM_READ.
REQ-011 SHALL hold mem_read=1 and mem_address stable throughout MEM_READ.
REQ-012 SHALL stay in MEM_READ for at least one full cycle, then leave at the first subsequent posedge sampling mem_busywait=0.
REQ-013 SHALL, at that posedge, capture mem_readdata and enter UPDATE with mem_read deasserted.
REQ-014 SHALL, in UPDATE, write the block, latched tag and valid=1 to the latched index, then return to IDLE at the next posedge; the access then hits.
REQ-015 SHALL ignore address/read changes during MEM_READ/UPDATE; the fill completes for the latched block, then IDLE re-evaluates the current address.
REQ-016 SHALL replace a valid line with a different tag unconditionally; there are no dirty lines and no write-back.

Reset
REQ-017 SHALL, on posedge with reset=1: clear all valid bits, enter IDLE, force mem_read=0 and mem_address=6'd0.
REQ-018 SHALL drive busywait=0 while reset is asserted.
REQ-019 SHALL, on reset during MEM_READ or UPDATE, abandon the fill with no line written.

Configuration
REQ-020 SHALL, with ICACHE_STATS_EN defined, add outputs hit_count[15:0] and miss_count[15:0]:
- reset to 0
- hit_count +1 per cycle with a hit in IDLE
- miss_count +1 per IDLE->MEM_READ transition
- both saturate at 16'hFFFF
REQ-021 SHALL, without ICACHE_STATS_EN, omit these ports and counters entirely.

Structure
REQ-022 SHALL place in package icache_pkg:
- constants TAG_W=3, INDEX_W=3, OFFSET_W=2 and NUM_LINES
- state enum {IDLE, MEM_READ, UPDATE}
REQ-023 SHALL implement the tag/valid/data storage as sub-module icache_line_array: one write port, combinational read; the FSM stays in icache_ctrl.

Verification
REQ-024 Bench SHALL cover:
- Cold miss: reset, read=1, address=10'h000 -> busywait=1; next edge mem_read=1, mem_address=6'd0; memory returns word0=32'h0004_0019 -> after UPDATE, readinst=32'h00040019, busywait=0.
- Hit: after the cold miss, address=10'h004 -> same cycle readinst=word1 (32'h0005_0023), busywait=0, mem_read stays 0.
- Conflict: address=10'h080 -> miss, mem_address=6'd8, line 0 replaced; address=10'h000 then misses again with mem_address=6'd0.
- Reset mid-fill: reset=1 for one cycle while in MEM_READ -> next edge mem_read=0, state IDLE; re-access of 10'h000 misses.
- Idle: read=0 while address sweeps 10'h000..10'h3FC -> busywait=0, mem_read=0 throughout.
- Stats (ICACHE_STATS_EN): 1 miss then 3 hits -> miss_count=1, hit_count=3.
